// File: rtl/v6502_pkg.sv
// v6502_pkg: shared types and constants for the v6502 front end.
//   pf_state_t   - prefetch fetch FSM states
//   ADDR_W       - bus address width
//   BYTE_W       - bus data width
//   RESET_PC_DEF - default fetch address after reset
package v6502_pkg;

  localparam int ADDR_W = 16;
  localparam int BYTE_W = 8;
  localparam logic [ADDR_W-1:0] RESET_PC_DEF = 16'h0000;

  typedef enum logic [1:0] {
    PF_IDLE,
    PF_REQ,
    PF_DROP
  } pf_state_t;

endpackage

// File: rtl/byte_ring.sv
// byte_ring: DEPTH x 8 circular byte buffer with 3-byte peek.
//   clk, rst_n        - clock, async active-low reset
//   clr               - synchronous clear of pointers and count (wins over push/pop)
//   push, push_data   - write one byte at the tail
//   pop, pop_len      - advance head by pop_len bytes (caller guarantees legality)
//   count             - bytes held, 0..DEPTH
//   peek0..peek2      - combinational bytes at head, head+1, head+2
module byte_ring
  import v6502_pkg::*;
#(
  parameter int DEPTH = 16,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = PW + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              push,
  input  logic [BYTE_W-1:0] push_data,
  input  logic              pop,
  input  logic [1:0]        pop_len,
  output logic [CW-1:0]     count,
  output logic [BYTE_W-1:0] peek0,
  output logic [BYTE_W-1:0] peek1,
  output logic [BYTE_W-1:0] peek2
);

  logic [BYTE_W-1:0] mem [DEPTH];
  logic [PW-1:0]     head;
  logic [PW-1:0]     tail;
  logic [CW-1:0]     pop_amt;

  assign pop_amt = pop ? CW'(pop_len) : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (clr) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) begin
        mem[tail] <= push_data;
        tail      <= tail + PW'(1);
      end
      if (pop) head <= head + PW'(pop_len);
      count <= count + CW'(push) - pop_amt;
    end
  end

  // Pointer arithmetic is PW bits wide, so head+1/head+2 wrap mod DEPTH.
  assign peek0 = mem[head];
  assign peek1 = mem[head + PW'(1)];
  assign peek2 = mem[head + PW'(2)];

endmodule

// File: rtl/inst_prefetch_queue.sv
// inst_prefetch_queue: sequential instruction byte prefetcher feeding the decoder.
//   mem_req/mem_addr/mem_ack/mem_rdata - single-outstanding byte fetch bus
//   q_byte0..2, q_count                 - next three bytes and fill level
//   dec_consume, dec_len                - decoder retires 1..3 bytes
//   flush, flush_pc                     - discard queue, redirect fetch
//   fetch_pc                            - address of the next byte to request
//   len_err                             - sticky illegal-consume flag
// Optional: define PREFETCH_STALL_CNT_EN to add stall_cnt[15:0], a saturating
// count of cycles with fewer than three bytes queued (cleared on flush).
module inst_prefetch_queue
  import v6502_pkg::*;
#(
  parameter int                DEPTH    = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = RESET_PC_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [BYTE_W-1:0] mem_rdata,
  output logic [BYTE_W-1:0] q_byte0,
  output logic [BYTE_W-1:0] q_byte1,
  output logic [BYTE_W-1:0] q_byte2,
  output logic [4:0]        q_count,
  input  logic              dec_consume,
  input  logic [1:0]        dec_len,
  input  logic              flush,
  input  logic [ADDR_W-1:0] flush_pc,
  output logic [ADDR_W-1:0] fetch_pc,
  output logic              len_err
`ifdef PREFETCH_STALL_CNT_EN
  ,
  output logic [15:0]       stall_cnt
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [4:0] DEPTH_C = 5'(DEPTH);

  pf_state_t     state;
  logic          push;
  logic          consume_ok;
  logic          consume_bad;
  logic [PW:0]   ring_count;

  // Legality is judged against the count before any same-cycle push.
  assign consume_ok  = dec_consume && (dec_len != 2'd0) && ({3'b000, dec_len} <= q_count);
  assign consume_bad = dec_consume && !consume_ok;

  // A byte acked in DROP, or in the same cycle as a flush, is discarded.
  assign push    = (state == PF_REQ) && mem_ack && !flush;
  assign mem_req = (state != PF_IDLE);
  assign q_count = 5'(ring_count);

  byte_ring #(.DEPTH(DEPTH)) u_ring (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (flush),
    .push      (push),
    .push_data (mem_rdata),
    .pop       (consume_ok && !flush),
    .pop_len   (dec_len),
    .count     (ring_count),
    .peek0     (q_byte0),
    .peek1     (q_byte1),
    .peek2     (q_byte2)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= PF_IDLE;
      mem_addr <= RESET_PC;
      fetch_pc <= RESET_PC;
      len_err  <= 1'b0;
    end else begin
      if (consume_bad) len_err <= 1'b1;

      if (flush)     fetch_pc <= flush_pc;
      else if (push) fetch_pc <= fetch_pc + 16'd1;

      // The bus has no abort: a flushed request stays on the bus until acked.
      case (state)
        PF_IDLE: begin
          if (!flush && (q_count < DEPTH_C)) begin
            state    <= PF_REQ;
            mem_addr <= fetch_pc;
          end
        end
        PF_REQ: begin
          if (mem_ack)    state <= PF_IDLE;
          else if (flush) state <= PF_DROP;
        end
        PF_DROP: begin
          if (mem_ack) state <= PF_IDLE;
        end
        default: state <= PF_IDLE;
      endcase
    end
  end

`ifdef PREFETCH_STALL_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                 stall_cnt <= '0;
    else if (flush)                             stall_cnt <= '0;
    else if ((q_count < 5'd3) && (stall_cnt != '1)) stall_cnt <= stall_cnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_inst_prefetch_queue.sv
module tb_inst_prefetch_queue;

  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mem_req, mem_ack;
  logic [15:0] mem_addr, flush_pc, fetch_pc;
  logic [7:0]  mem_rdata, q_byte0, q_byte1, q_byte2;
  logic [4:0]  q_count;
  logic        dec_consume, flush, len_err;
  logic [1:0]  dec_len;

  logic        mem_req2, ack2, len_err2;
  logic [15:0] mem_addr2, fetch_pc2;
  logic [7:0]  rdata2, qb20, qb21, qb22;
  logic [4:0]  q_count2;
`ifdef PREFETCH_STALL_CNT_EN
  logic [15:0] stall_cnt, stall_cnt2;
`endif

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  inst_prefetch_queue #(.DEPTH(DEPTH), .RESET_PC(16'h0000)) dut (
    .clk(clk), .rst_n(rst_n), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .q_byte0(q_byte0),
    .q_byte1(q_byte1), .q_byte2(q_byte2), .q_count(q_count),
    .dec_consume(dec_consume), .dec_len(dec_len), .flush(flush),
    .flush_pc(flush_pc), .fetch_pc(fetch_pc), .len_err(len_err)
`ifdef PREFETCH_STALL_CNT_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  inst_prefetch_queue #(.DEPTH(DEPTH), .RESET_PC(16'hFFFE)) dut_wrap (
    .clk(clk), .rst_n(rst_n), .mem_req(mem_req2), .mem_addr(mem_addr2),
    .mem_ack(ack2), .mem_rdata(rdata2), .q_byte0(qb20),
    .q_byte1(qb21), .q_byte2(qb22), .q_count(q_count2),
    .dec_consume(1'b0), .dec_len(2'd0), .flush(1'b0),
    .flush_pc(16'h0000), .fetch_pc(fetch_pc2), .len_err(len_err2)
`ifdef PREFETCH_STALL_CNT_EN
    , .stall_cnt(stall_cnt2)
`endif
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Memory image: first three bytes fixed, the rest derived from the address.
  function automatic logic [7:0] mem_data(input logic [15:0] a);
    case (a)
      16'h0000: return 8'hA9;
      16'h0001: return 8'h05;
      16'h0002: return 8'h8D;
      default:  return a[7:0] ^ a[15:8] ^ 8'h3C;
    endcase
  endfunction

  // Behavioural model: byte queue plus one outstanding bus transaction.
  logic [7:0]  mq[$];
  logic [15:0] m_fpc, m_addr, m_stall;
  bit          m_busy, m_drop, m_lerr;

  // Bus responder control.
  bit ack_hold, rand_delay, spurious;
  int wait_cnt, ack_delay;

  task automatic model_reset();
    mq.delete();
    m_fpc = 16'h0000; m_addr = 16'h0000; m_stall = 16'h0000;
    m_busy = 0; m_drop = 0; m_lerr = 0;
    wait_cnt = 0;
  endtask

  task automatic model_step(input bit a, input logic [7:0] rd, input bit c,
                            input logic [1:0] l, input bit f, input logic [15:0] fp);
    int cnt;
    cnt = mq.size();
    if (f) m_stall = 16'h0000;
    else if (cnt < 3 && m_stall != 16'hFFFF) m_stall = m_stall + 16'd1;
    if (c) begin
      if (l == 2'd0 || int'(l) > cnt) m_lerr = 1;
      else if (!f) repeat (int'(l)) void'(mq.pop_front());
    end
    if (m_busy && a && !m_drop && !f) begin
      mq.push_back(rd);
      m_fpc = m_fpc + 16'd1;
    end
    if (f) begin
      mq.delete();
      m_fpc = fp;
    end
    if (!m_busy) begin
      if (!f && cnt < DEPTH) begin
        m_busy = 1;
        m_addr = m_fpc;
      end
    end else if (a) begin
      m_busy = 0;
      m_drop = 0;
    end else if (f) begin
      m_drop = 1;
    end
  endtask

  task automatic compare();
    chk("mem_req", 32'(mem_req), 32'(m_busy));
    if (m_busy) chk("mem_addr", 32'(mem_addr), 32'(m_addr));
    chk("q_count", 32'(q_count), 32'(mq.size()));
    chk("fetch_pc", 32'(fetch_pc), 32'(m_fpc));
    chk("len_err", 32'(len_err), 32'(m_lerr));
    if (mq.size() > 0) chk("q_byte0", 32'(q_byte0), 32'(mq[0]));
    if (mq.size() > 1) chk("q_byte1", 32'(q_byte1), 32'(mq[1]));
    if (mq.size() > 2) chk("q_byte2", 32'(q_byte2), 32'(mq[2]));
`ifdef PREFETCH_STALL_CNT_EN
    chk("stall_cnt", 32'(stall_cnt), 32'(m_stall));
`endif
  endtask

  // One clock cycle: entered and left at a falling edge.
  task automatic tick(input bit c, input logic [1:0] l, input bit f, input logic [15:0] fp);
    bit a;
    bit was_busy;
    logic [7:0] rd;
    compare();
    a = 0;
    rd = 8'($urandom);
    was_busy = m_busy;
    if (m_busy && !ack_hold) begin
      if (wait_cnt >= ack_delay) begin
        a = 1;
        rd = mem_data(m_addr);
      end else wait_cnt++;
    end else if (!m_busy && spurious && $urandom_range(0, 15) == 0) a = 1;
    mem_ack = a; mem_rdata = rd; dec_consume = c; dec_len = l; flush = f; flush_pc = fp;
    model_step(a, rd, c, l, f, fp);
    if (a && was_busy) begin
      wait_cnt = 0;
      ack_delay = rand_delay ? int'($urandom_range(0, 3)) : 1;
    end
    @(negedge clk);
  endtask

  task automatic rand_tick();
    bit c, f;
    logic [1:0] l;
    c = ($urandom_range(0, 9) < 4);
    l = ($urandom_range(0, 9) == 0) ? 2'd0 : 2'($urandom_range(1, 3));
    f = ($urandom_range(0, 39) == 0);
    tick(c, l, f, 16'($urandom));
  endtask

  task automatic idle_inputs();
    mem_ack = 0; mem_rdata = 8'h00; dec_consume = 0; dec_len = 2'd0;
    flush = 0; flush_pc = 16'h0000;
  endtask

  // Second instance: RESET_PC near the top of memory, acked one cycle after request.
  logic [15:0] exp2[3];
  int n2 = 0;
  initial begin
    bit w2;
    exp2[0] = 16'hFFFE; exp2[1] = 16'hFFFF; exp2[2] = 16'h0000;
    ack2 = 0; rdata2 = 8'h00; w2 = 0;
    forever begin
      @(negedge clk);
      ack2 = 0;
      if (rst_n && mem_req2) begin
        if (w2) begin
          ack2 = 1;
          w2 = 0;
          if (n2 < 3) chk("wrap_mem_addr", 32'(mem_addr2), 32'(exp2[n2]));
          n2++;
        end else w2 = 1;
      end else w2 = 0;
    end
  end

  initial begin
    int n;
    idle_inputs();
    rst_n = 0;
    ack_hold = 0; rand_delay = 0; spurious = 0; ack_delay = 1;
    model_reset();
    repeat (3) @(negedge clk);
    chk("rst_mem_req", 32'(mem_req), 32'h0);
    chk("rst_mem_addr", 32'(mem_addr), 32'h0000);
    chk("rst_fetch_pc", 32'(fetch_pc), 32'h0000);
    chk("rst_q_count", 32'(q_count), 32'h0);
    chk("rst_q_byte0", 32'(q_byte0), 32'h00);
    chk("rst_len_err", 32'(len_err), 32'h0);
    rst_n = 1;

    // Fill with no consumption.
    n = 0;
    while (mq.size() < 3 && n < 50) begin tick(0, 2'd0, 0, 16'h0); n++; end
    chk("fill3_count", 32'(q_count), 32'd3);
    chk("fill3_b0", 32'(q_byte0), 32'hA9);
    chk("fill3_b1", 32'(q_byte1), 32'h05);
    chk("fill3_b2", 32'(q_byte2), 32'h8D);
    while (mq.size() < DEPTH && n < 200) begin tick(0, 2'd0, 0, 16'h0); n++; end
    repeat (4) tick(0, 2'd0, 0, 16'h0);
    chk("full_count", 32'(q_count), 32'd16);
    chk("full_mem_req", 32'(mem_req), 32'h0);
    chk("full_fetch_pc", 32'(fetch_pc), 32'h0010);

    // Consume 3 from full, then a new request from 0x0010.
    ack_hold = 1;
    tick(1, 2'd3, 0, 16'h0);
    chk("cons3_count", 32'(q_count), 32'd13);
    tick(0, 2'd0, 0, 16'h0);
    chk("refetch_req", 32'(mem_req), 32'h1);
    chk("refetch_addr", 32'(mem_addr), 32'h0010);

    // Flush while the request is pending; ack lands two cycles later.
    tick(0, 2'd0, 1, 16'hC000);
    chk("drop_req_held", 32'(mem_req), 32'h1);
    chk("drop_addr_held", 32'(mem_addr), 32'h0010);
    chk("drop_count", 32'(q_count), 32'd0);
    chk("drop_fetch_pc", 32'(fetch_pc), 32'hC000);
    tick(0, 2'd0, 0, 16'h0);
    chk("drop_still_req", 32'(mem_req), 32'h1);
    ack_hold = 0; ack_delay = 0;
    tick(0, 2'd0, 0, 16'h0);
    chk("drop_discard_count", 32'(q_count), 32'd0);
    chk("drop_idle", 32'(mem_req), 32'h0);
    tick(0, 2'd0, 0, 16'h0);
    chk("redirect_addr", 32'(mem_addr), 32'hC000);

    // Over-length consume with one byte queued.
    n = 0;
    while (mq.size() < 1 && n < 20) begin tick(0, 2'd0, 0, 16'h0); n++; end
    chk("pre_len_err", 32'(len_err), 32'h0);
    tick(1, 2'd2, 0, 16'h0);
    chk("len_err_set", 32'(len_err), 32'h1);
    chk("len_err_head", 32'(q_byte0), 32'(mem_data(16'hC000)));
    tick(0, 2'd0, 1, 16'h0200);
    chk("len_err_sticky", 32'(len_err), 32'h1);
    chk("flush_count", 32'(q_count), 32'd0);

    // Randomized traffic.
    rand_delay = 1; spurious = 1;
    repeat (1500) rand_tick();

    // Asynchronous reset mid-traffic, then more random traffic.
    idle_inputs();
    #2 rst_n = 0;
    model_reset();
    @(negedge clk);
    chk("mid_rst_mem_req", 32'(mem_req), 32'h0);
    chk("mid_rst_count", 32'(q_count), 32'd0);
    chk("mid_rst_len_err", 32'(len_err), 32'h0);
    chk("mid_rst_fetch_pc", 32'(fetch_pc), 32'h0000);
    rst_n = 1;
    repeat (1500) rand_tick();
    compare();

    if (n2 < 3) chk("wrap_ack_count", 32'(n2), 32'd3);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/inst_prefetch_queue.md
Name: inst_prefetch_queue

Overview:
Instruction prefetch stage that sits directly upstream of prime_decoder. It fetches opcode and operand bytes sequentially from the memory bus and buffers them in a 16-entry byte FIFO. It presents the next three bytes to the decoder, and retires 1-3 bytes per cycle as reported by the decoder's instruction-length output. A taken branch, jump or interrupt flushes the queue and redirects fetch to a new PC.

Parameters:
DEPTH, 16, queue entries; power of 2; pointer width = log2(DEPTH).
RESET_PC, 16'h0000, fetch address loaded at reset.

Ports:
clk  in  1  core clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
mem_req  out  1  fetch request; held until mem_ack.
mem_addr  out  16  fetch byte address; stable while mem_req=1.
mem_ack  in  1  request complete; mem_rdata valid in the same cycle.
mem_rdata  in  8  fetched byte.
q_byte0  out  8  head byte (opcode).
q_byte1  out  8  head+1 byte.
q_byte2  out  8  head+2 byte.
q_count  out  5  bytes held, 0..DEPTH.
dec_consume  in  1  retire dec_len bytes this cycle.
dec_len  in  2  bytes to retire, 1..3; 0 = no-op.
flush  in  1  discard queue, redirect fetch.
flush_pc  in  16  new fetch address when flush=1.
fetch_pc  out  16  address of the next byte to request.
len_err  out  1  sticky; set on an illegal consume.

Behaviour:
- Reset (async, rst_n=0) values:
  - mem_req=0; mem_addr=RESET_PC; fetch_pc=RESET_PC.
  - Head/tail pointers 0; q_count=0; q_byte0..2=0; len_err=0.
  - FSM=IDLE.
  - Reset asserted mid-request abandons that request; any later mem_ack is ignored while FSM=IDLE with mem_req=0.
- FSM has three states: IDLE, REQ, DROP.
  - IDLE -> REQ when flush=0 and q_count < DEPTH. Asserts mem_req with mem_addr=fetch_pc.
  - REQ + mem_ack:
    - write mem_rdata at the tail;
    - tail+1 (wraps mod DEPTH);
    - fetch_pc+1 (wraps 16'hFFFF -> 16'h0000);
    - -> IDLE, so at most one request per two cycles.
  - REQ + flush (no ack): -> DROP. mem_req and mem_addr stay held (the bus has no abort).
  - REQ + flush + mem_ack in the same cycle: the byte is discarded; -> IDLE.
  - DROP + mem_ack: byte discarded; -> IDLE. DROP ignores further flushes except to update fetch_pc.
- Queue write: a byte written on an ack edge is visible on q_byte* and in q_count from the next cycle. There is no bypass path.
- q_byte0..2 are combinational reads at head, head+1, head+2 (mod DEPTH). Slots >= q_count hold stale data and are don't-care.
- Consume:
  - When dec_consume=1 and 1 <= dec_len <= q_count: head += dec_len (mod DEPTH).
  - When dec_len > q_count or dec_len=0 with dec_consume=1: no pointer change; len_err<=1.
- Simultaneous push and consume: q_count_next = q_count + push - dec_len. Full (q_count=DEPTH) with a consume frees space, and the next IDLE cycle may issue.
- Overflow is impossible: a request issues only when q_count < DEPTH, and there is only one outstanding request.
- Flush:
  - next cycle q_count=0, head=tail=0, fetch_pc=flush_pc;
  - flush beats a same-cycle consume and push;
  - len_err is not cleared by flush (reset only).
- All state registered on the rising clk edge; only q_byte* are combinational.

Optional Feature:
- Macro PREFETCH_STALL_CNT_EN.
- Defined:
  - adds output stall_cnt[15:0], reset 0;
  - increments (saturating at 16'hFFFF) each cycle that q_count < 3 and flush=0;
  - cleared on flush.
- Undefined: the port and counter are absent; behaviour is otherwise identical.

Decomposition:
- Shared package v6502_pkg holds:
  - FSM state typedef pf_state_t {PF_IDLE, PF_REQ, PF_DROP};
  - localparam ADDR_W=16, BYTE_W=8;
  - RESET_PC default.
- One natural sub-module: byte_ring (DEPTH x 8 storage with wrap-around pointers, count, 3-byte peek). The FSM and PC logic stay in the top module.

Test Plan:
- Reset, memory returns 8'hA9,8'h05,8'h8D,... with ack one cycle after req:
  - mem_addr walks 0,1,2...;
  - q_count reaches 3 after the third ack;
  - q_byte0..2 = A9,05,8D.
- Decoder never consumes: q_count saturates at 16; mem_req stays 0 afterward; fetch_pc = 16'h0010.
- q_count=16 with dec_consume=1, dec_len=3: q_count=13 next cycle; a new request issues from fetch_pc=16'h0010.
- flush with flush_pc=16'hC000 while REQ is pending and ack arrives 2 cycles later:
  - FSM passes through DROP;
  - acked byte discarded; q_count=0;
  - next mem_addr=16'hC000.
- RESET_PC=16'hFFFE, three acks: mem_addr sequence FFFE, FFFF, 0000.
- q_count=1, dec_consume=1, dec_len=2: head unchanged; len_err=1 and remains 1 after a subsequent flush.
